// File: rtl/ifetch_unit.sv
// Instruction fetch stage: single outstanding imem read, timeout, flush with late-response drop.
// Optional performance counters enabled by defining IFETCH_PERF_CNT_EN.
module ifetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] RESET_INSTR    = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        fetch_start,
    input  logic        flush,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code,
    input  logic        fault_clr
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_TIMEOUT  = 2'b10
    } fault_e;

    state_e        state_q;
    fault_e        fault_code_q;
    logic [TW-1:0] timer_q;
    logic [31:0]   addr_q;
    logic [31:0]   instr_q;
    logic [31:0]   instr_pc_q;
    logic          instr_valid_q;
    logic          imem_rd_en_q;
    logic          fault_q;
    logic          drop_pending_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            fault_code_q   <= FC_NONE;
            timer_q        <= '0;
            addr_q         <= '0;
            instr_q        <= RESET_INSTR;
            instr_pc_q     <= '0;
            instr_valid_q  <= 1'b0;
            imem_rd_en_q   <= 1'b0;
            fault_q        <= 1'b0;
            drop_pending_q <= 1'b0;
        end else begin
            imem_rd_en_q <= 1'b0;
            // The response owed to an aborted request is swallowed whatever state we are in.
            if (drop_pending_q && imem_rvalid) begin
                drop_pending_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (fetch_start && !drop_pending_q) begin
                        if (pc[1:0] != 2'b00) begin
                            state_q      <= S_FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_MISALIGN;
                            instr_pc_q   <= pc;
                        end else begin
                            addr_q       <= pc;
                            imem_rd_en_q <= 1'b1;
                            state_q      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        state_q        <= S_IDLE;
                        drop_pending_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                        timer_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        if (!imem_rvalid) begin
                            drop_pending_q <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= addr_q;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_HOLD;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q        <= S_FAULT;
                        fault_q        <= 1'b1;
                        fault_code_q   <= FC_TIMEOUT;
                        drop_pending_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (flush || instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        fault_q      <= 1'b0;
                        fault_code_q <= FC_NONE;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (instr_valid_q && instr_ready) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (state_q == S_WAIT && !imem_rvalid) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

    assign imem_rd_en  = imem_rd_en_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign busy        = (state_q != S_IDLE) || drop_pending_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit; fetched words are checked against a scoreboard queue.
// Counter checks are compiled in when IFETCH_PERF_CNT_EN is defined.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_start;
    logic        flush;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;
    logic        fault_clr;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] exp_instr = NOP;
    logic [31:0] exp_pc = 32'h0;

    ifetch_unit #(
        .TIMEOUT_CYCLES(4),
        .RESET_INSTR   (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .fetch_start(fetch_start),
        .flush      (flush),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_rvalid(imem_rvalid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_clr  (fault_clr)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare any newly presented instruction with the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (instr_valid === 1'b1 && !prev_valid) begin
            chk("sb_pending", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("instr", instr, e.word);
                chk("instr_pc", instr_pc, e.addr);
                exp_instr = e.word;
                exp_pc    = e.addr;
            end
        end else if (instr_valid === 1'b1) begin
            chk("hold_instr", instr, exp_instr);
            chk("hold_pc", instr_pc, exp_pc);
        end
        prev_valid = (instr_valid === 1'b1);
    endtask

    task automatic fetch_ok(input logic [31:0] a, input logic [31:0] d,
                            input int unsigned stall, input int unsigned hold);
        pc = a;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("rd_en", imem_rd_en, 32'd1);
        chk("addr", imem_addr, a);
        step();
        chk("rd_en_pulse", imem_rd_en, 32'd0);
        for (int unsigned i = 0; i < stall; i++) step();
        chk("wait_busy", busy, 32'd1);
        instr_ready = (hold == 0);
        imem_rdata  = d;
        imem_rvalid = 1'b1;
        sb.push_back('{word: d, addr: a});
        step();
        imem_rvalid = 1'b0;
        chk("valid_rise", instr_valid, 32'd1);
        for (int unsigned i = 0; i < hold; i++) begin
            pc = a + 32'h40;
            fetch_start = 1'b1;
            step();
            chk("hold_valid", instr_valid, 32'd1);
            chk("hold_no_req", imem_rd_en, 32'd0);
        end
        fetch_start = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("valid_fall", instr_valid, 32'd0);
        chk("idle_busy", busy, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        pc = '0;
        fetch_start = 1'b0;
        flush = 1'b0;
        imem_rdata = '0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        fault_clr = 1'b0;
        step();
        step();
        chk("rst_rd_en", imem_rd_en, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_valid", instr_valid, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_fault", fault, 32'd0);
        chk("rst_code", fault_code, 32'd0);
        reset = 1'b1;
        step();

        // minimum latency fetch
        fetch_ok(32'h100, 32'h00500093, 0, 0);

        // misaligned pc
        pc = 32'h102;
        fetch_start = 1'b1;
        step();
        chk("mis_rd_en", imem_rd_en, 32'd0);
        chk("mis_fault", fault, 32'd1);
        chk("mis_code", fault_code, 32'd1);
        chk("mis_pc", instr_pc, 32'h102);
        exp_pc = 32'h102;
        pc = 32'h100;
        step();
        fetch_start = 1'b0;
        chk("fault_ignore_fetch", imem_rd_en, 32'd0);
        flush = 1'b1;
        step();
        chk("fault_flush_noeffect", fault, 32'd1);
        fault_clr = 1'b1;
        step();
        flush = 1'b0;
        fault_clr = 1'b0;
        chk("clr_fault", fault, 32'd0);
        chk("clr_code", fault_code, 32'd0);
        chk("clr_busy", busy, 32'd0);

        // timeout after four WAIT cycles, then late data dropped
        pc = 32'h140;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        repeat (3) step();
        chk("to_not_yet", fault, 32'd0);
        step();
        chk("to_fault", fault, 32'd1);
        chk("to_code", fault_code, 32'd2);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("to_clr_busy", busy, 32'd1);
        pc = 32'h180;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("drop_ignore_fetch", imem_rd_en, 32'd0);
        imem_rdata = 32'hDEADBEEF;
        imem_rvalid = 1'b1;
        step();
        imem_rvalid = 1'b0;
        chk("late_valid", instr_valid, 32'd0);
        chk("late_instr", instr, exp_instr);
        chk("late_pc", instr_pc, exp_pc);
        chk("late_busy", busy, 32'd0);

        // backpressure for five cycles
        fetch_ok(32'h104, 32'h00108093, 1, 5);

        // flush in WAIT, fetch while drop pending, then retry
        pc = 32'h1C0;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_wait_busy", busy, 32'd1);
        pc = 32'h200;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("flush_ignore_fetch", imem_rd_en, 32'd0);
        imem_rdata = 32'hBADBAD00;
        imem_rvalid = 1'b1;
        step();
        imem_rvalid = 1'b0;
        chk("old_dropped_valid", instr_valid, 32'd0);
        chk("old_dropped_busy", busy, 32'd0);
        fetch_ok(32'h200, 32'h00A00113, 0, 0);

        // flush coincident with rvalid: no drop pending
        pc = 32'h240;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        flush = 1'b1;
        imem_rdata = 32'h12345678;
        imem_rvalid = 1'b1;
        step();
        flush = 1'b0;
        imem_rvalid = 1'b0;
        chk("flush_rv_valid", instr_valid, 32'd0);
        chk("flush_rv_busy", busy, 32'd0);
        fetch_ok(32'h244, 32'h00208113, 0, 0);

        // flush in REQ
        pc = 32'h2C0;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_req_busy", busy, 32'd1);
        imem_rdata = 32'h0BAD0BAD;
        imem_rvalid = 1'b1;
        step();
        imem_rvalid = 1'b0;
        chk("flush_req_drop", busy, 32'd0);
        chk("flush_req_valid", instr_valid, 32'd0);

        // flush in HOLD
        pc = 32'h280;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        instr_ready = 1'b0;
        imem_rdata = 32'h00300193;
        imem_rvalid = 1'b1;
        sb.push_back('{word: 32'h00300193, addr: 32'h280});
        step();
        imem_rvalid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        instr_ready = 1'b1;
        chk("flush_hold_valid", instr_valid, 32'd0);
        chk("flush_hold_busy", busy, 32'd0);

        // asynchronous reset in the middle of WAIT
        pc = 32'h300;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("arst_rd_en", imem_rd_en, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_instr", instr, NOP);
        chk("arst_instr_pc", instr_pc, 32'd0);
        chk("arst_valid", instr_valid, 32'd0);
        chk("arst_busy", busy, 32'd0);
        chk("arst_fault", fault, 32'd0);
        chk("arst_code", fault_code, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk("arst_fetch_cnt", fetch_count, 32'd0);
        chk("arst_stall_cnt", stall_count, 32'd0);
`endif
        exp_instr = NOP;
        exp_pc = 32'h0;
        reset = 1'b1;
        imem_rdata = 32'h11111111;
        imem_rvalid = 1'b1;
        step();
        imem_rvalid = 1'b0;
        chk("arst_stale_valid", instr_valid, 32'd0);
        chk("arst_stale_instr", instr, NOP);

        // three fetches with a two-cycle stall each
        fetch_ok(32'h400, 32'h00400213, 2, 0);
        fetch_ok(32'h404, 32'h00500293, 2, 0);
        fetch_ok(32'h408, 32'h00600313, 2, 0);
`ifdef IFETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, 32'd3);
        chk("stall_count", stall_count, 32'd6);
`endif

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
